cordic_engine: RTL and testbench

Iterative, parametrised CORDIC engine that wraps a single width-generic iteration stage with its own arctan/artanh LUT, iteration sequencer and start/done handshake. It supports circular and hyperbolic coordinates, in both rotation and vectoring mode. Hyperbolic runs include the mandatory repeat iterations (shift 4 and 13). It is the successor to the bench-driven single-stage CORDIC and is the compute core for the accelerator's register front-end.

---
 rtl/cordic_pkg.sv | 41 ++++
 rtl/cordic_stage.sv | 49 ++++
 rtl/cordic_engine.sv | 133 +++++++++++++
 tb/tb_cordic_engine.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared FSM type, hyperbolic repeat points and angle LUTs for the CORDIC engine
// Contents:
//   state_t          engine FSM states
//   c_HYP_REPEAT_A/B shift values that hyperbolic mode executes twice
//   c_ATAN_LUT       atan(2^-i), 32-bit, 2^31 = 180 degrees (pi rad)
//   c_ATANH_LUT      atanh(2^-i), same scaling; entry 0 is never used
package cordic_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] c_HYP_REPEAT_A = 5'd4;
  localparam logic [4:0] c_HYP_REPEAT_B = 5'd13;

  localparam logic [31:0] c_ATAN_LUT [32] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // atanh(1) is infinite; hyperbolic runs start at shift 1 so slot 0 is unused and held at zero.
  localparam logic [31:0] c_ATANH_LUT [32] = '{
    32'd0,         32'd375486606, 32'd174591329, 32'd85894908,
    32'd42778589,  32'd21368373,  32'd10681577,  32'd5340462,
    32'd2670190,   32'd1335090,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one combinational CORDIC micro-iteration, circular or hyperbolic
// Ports:
//   x, y, z              current working values (signed, p_WIDTH)
//   mode                 1 = circular, 0 = hyperbolic
//   vector               1 = vectoring (drive y to 0), 0 = rotation (drive z to 0)
//   shift                shift amount for this iteration
//   lut                  32-bit angle for this shift; top p_WIDTH bits are used
//   x_next/y_next/z_next next working values
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32
) (
  input  logic signed [p_WIDTH-1:0] x,
  input  logic signed [p_WIDTH-1:0] y,
  input  logic signed [p_WIDTH-1:0] z,
  input  logic                      mode,
  input  logic                      vector,
  input  logic        [4:0]         shift,
  input  logic        [31:0]        lut,
  output logic signed [p_WIDTH-1:0] x_next,
  output logic signed [p_WIDTH-1:0] y_next,
  output logic signed [p_WIDTH-1:0] z_next
);

  logic signed [p_WIDTH-1:0] x_sh;
  logic signed [p_WIDTH-1:0] y_sh;
  logic signed [p_WIDTH-1:0] angle;
  logic                      d_pos;

  always_comb begin
    x_sh  = x >>> shift;
    y_sh  = y >>> shift;
    // Narrow datapaths keep the most significant bits of the 32-bit angle.
    angle = p_WIDTH'($signed(lut) >>> (32 - p_WIDTH));
    d_pos = vector ? y[p_WIDTH-1] : ~z[p_WIDTH-1];

    if (d_pos) begin
      x_next = mode ? (x - y_sh) : (x + y_sh);
      y_next = y + x_sh;
      z_next = z - angle;
    end else begin
      x_next = mode ? (x + y_sh) : (x - y_sh);
      y_next = y - x_sh;
      z_next = z + angle;
    end
  end

endmodule

// File: rtl/cordic_engine.sv
// rtl/cordic_engine.sv - iterative CORDIC engine: start/done handshake, shift sequencer, working and output registers
// Ports:
//   i_clk, i_rst_n         clock (rising edge), synchronous active-low reset
//   i_start                start request, accepted only while o_ready=1
//   i_mode, i_vector       1 = circular / 0 = hyperbolic; 1 = vectoring / 0 = rotation
//   i_x, i_y, i_z          signed initial values, latched at start
//   o_ready                engine idle
//   o_done                 one-cycle pulse when o_x/o_y/o_z update
//   o_x, o_y, o_z          results, held until the next o_done
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32,
  parameter int p_ITER  = 20
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic                      i_vector,
  input  logic signed [p_WIDTH-1:0] i_x,
  input  logic signed [p_WIDTH-1:0] i_y,
  input  logic signed [p_WIDTH-1:0] i_z,
  output logic                      o_ready,
  output logic                      o_done,
  output logic signed [p_WIDTH-1:0] o_x,
  output logic signed [p_WIDTH-1:0] o_y,
  output logic signed [p_WIDTH-1:0] o_z
);

  localparam logic [4:0] c_LAST = 5'(p_ITER - 1);

  state_t                    state;
  logic        [4:0]         count;
  logic        [4:0]         shift;
  logic                      rep_flag;
  logic                      circ;
  logic                      vec;
  logic signed [p_WIDTH-1:0] acc_x;
  logic signed [p_WIDTH-1:0] acc_y;
  logic signed [p_WIDTH-1:0] acc_z;
  logic signed [p_WIDTH-1:0] nx;
  logic signed [p_WIDTH-1:0] ny;
  logic signed [p_WIDTH-1:0] nz;
  logic        [31:0]        lut;
  logic                      hold_shift;

  assign lut = circ ? c_ATAN_LUT[shift] : c_ATANH_LUT[shift];

  // Hyperbolic convergence needs shifts 4 and 13 executed twice; the flag
  // marks that the first pass of a repeated shift has already happened.
  assign hold_shift = !circ && !rep_flag &&
                      ((shift == c_HYP_REPEAT_A) || (shift == c_HYP_REPEAT_B));

  cordic_stage #(
    .p_WIDTH (p_WIDTH)
  ) u_stage (
    .x      (acc_x),
    .y      (acc_y),
    .z      (acc_z),
    .mode   (circ),
    .vector (vec),
    .shift  (shift),
    .lut    (lut),
    .x_next (nx),
    .y_next (ny),
    .z_next (nz)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      o_ready  <= 1'b1;
      o_done   <= 1'b0;
      o_x      <= '0;
      o_y      <= '0;
      o_z      <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      acc_z    <= '0;
      count    <= '0;
      shift    <= '0;
      rep_flag <= 1'b0;
      circ     <= 1'b0;
      vec      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            acc_x    <= i_x;
            acc_y    <= i_y;
            acc_z    <= i_z;
            circ     <= i_mode;
            vec      <= i_vector;
            count    <= '0;
            rep_flag <= 1'b0;
            shift    <= i_mode ? 5'd0 : 5'd1;
            o_ready  <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc_x <= nx;
          acc_y <= ny;
          acc_z <= nz;
          count <= count + 5'd1;
          if (hold_shift) begin
            rep_flag <= 1'b1;
          end else begin
            shift    <= shift + 5'd1;
            rep_flag <= 1'b0;
          end
          if (count == c_LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          o_x     <= acc_x;
          o_y     <= acc_y;
          o_z     <= acc_z;
          o_done  <= 1'b1;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// tb/tb_cordic_engine.sv - directed self-checking bench for cordic_engine (32-bit/20-iter and 16-bit/14-iter)
module tb_cordic_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start, mode, vector, ready, done;
  logic signed [31:0] x_in, y_in, z_in, o_x, o_y, o_z;

  logic               s_start, s_mode, s_vector, s_ready, s_done;
  logic signed [15:0] s_x, s_y, s_z, s_ox, s_oy, s_oz;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] shift_log [32];
  int hyp_seq [20] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15, 16, 17, 18};

  cordic_engine #(.p_WIDTH(32), .p_ITER(20)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_vector(vector),
    .i_x(x_in), .i_y(y_in), .i_z(z_in),
    .o_ready(ready), .o_done(done), .o_x(o_x), .o_y(o_y), .o_z(o_z)
  );

  cordic_engine #(.p_WIDTH(16), .p_ITER(14)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_mode(s_mode), .i_vector(s_vector),
    .i_x(s_x), .i_y(s_y), .i_z(s_z),
    .o_ready(s_ready), .o_done(s_done), .o_x(s_ox), .o_y(s_oy), .o_z(s_oz)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic near(input string tag, input int obs, input int exp, input int tol);
    longint diff;
    diff = longint'(obs) - longint'(exp);
    if (diff < 0) diff = -diff;
    n_tests++;
    assert (diff <= longint'(tol)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // Called on a negedge. Start is sampled at edge 0; lat is the edge after
  // which o_done is seen (-1 on timeout). At repulse_edge a second start and
  // a changed z are presented mid-run.
  task automatic run32(input logic m, input logic v, input logic signed [31:0] xi,
                       input logic signed [31:0] yi, input logic signed [31:0] zi,
                       input int repulse_edge, output int lat);
    mode = m; vector = v; x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("ready_low_after_start", int'(ready), 1'b0);
    shift_log[0] = dut.shift;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      start = (k == repulse_edge);
      if (k == repulse_edge) z_in = -zi;
      @(posedge clk);
      @(negedge clk);
      if (k < 32) shift_log[k] = dut.shift;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("ready_with_done", int'(ready), 1);
    @(posedge clk);
    @(negedge clk);
    chk("done_single_cycle", int'(done), 0);
  endtask

  initial begin
    int  lat, extra, d1, d2, r1x, r1y, r2x, r2y;
    int  c10, s10, hx0;
    real kh;

    c10 = $rtoi(0.98480775 * 2147483648.0);
    s10 = $rtoi(0.17364818 * 2147483648.0);

    rst_n = 1'b0; start = 1'b0; mode = 1'b1; vector = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    s_start = 1'b0; s_mode = 1'b1; s_vector = 1'b0; s_x = '0; s_y = '0; s_z = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", int'(ready), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_x", o_x, 0);
    chk("reset_y", o_y, 0);
    chk("reset_z", o_z, 0);
    chk("reset_ready16", int'(s_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Circular rotation by +10 degrees from (1/K, 0)
    run32(1'b1, 1'b0, 32'sh4DBA76D4, 32'sd0, 32'sh071C71C7, -1, lat);
    chk("circ_latency", lat, 21);
    near("circ_x", o_x, c10, 8192);
    near("circ_y", o_y, s10, 8192);
    near("circ_z", o_z, 0, 2048);
    chk("circ_shift_first", int'(shift_log[0]), 0);
    chk("circ_shift_last", int'(shift_log[19]), 19);

    // Hyperbolic rotation by 0.174533 in Q3.28, x pre-scaled by 1/K_h of the repeat sequence
    kh = 1.0;
    for (int i = 0; i < 20; i++) kh = kh * $sqrt(1.0 - 2.0 ** (-2.0 * hyp_seq[i]));
    hx0 = $rtoi(268435456.0 / kh + 0.5);
    run32(1'b0, 1'b0, hx0, 32'sd0, 32'sh071C71C7, -1, lat);
    chk("hyp_latency", lat, 21);
    near("hyp_cosh", o_x, $rtoi(1.0152696 * 268435456.0), 4096);
    near("hyp_sinh", o_y, $rtoi(0.1754204 * 268435456.0), 4096);
    for (int i = 0; i < 20; i++) chk($sformatf("hyp_shift_%0d", i), int'(shift_log[i]), hyp_seq[i]);

    // Circular vectoring of (0.25, 0.25): angle 45 degrees, magnitude K*0.35355
    run32(1'b1, 1'b1, 32'sh20000000, 32'sh20000000, 32'sd0, -1, lat);
    chk("vec_latency", lat, 21);
    near("vec_z", o_z, 32'sh20000000, 4096);
    near("vec_x", o_x, $rtoi(0.5822177 * 2147483648.0), 8192);
    near("vec_y", o_y, 0, 8192);

    // Second start (and new z) at edge 5 is ignored
    run32(1'b1, 1'b0, 32'sh4DBA76D4, 32'sd0, 32'sh071C71C7, 5, lat);
    chk("repulse_latency", lat, 21);
    near("repulse_x", o_x, c10, 8192);
    near("repulse_y", o_y, s10, 8192);
    extra = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (done) extra++;
    end
    chk("repulse_no_extra_done", extra, 0);

    // Reset at edge 10 of a run aborts it
    mode = 1'b1; vector = 1'b0; x_in = 32'sh4DBA76D4; y_in = '0; z_in = 32'sh071C71C7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_x", o_x, 0);
    chk("abort_y", o_y, 0);
    chk("abort_z", o_z, 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    extra = 0;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", extra, 0);
    run32(1'b1, 1'b0, 32'sh4DBA76D4, 32'sd0, 32'sh071C71C7, -1, lat);
    chk("after_abort_latency", lat, 21);
    near("after_abort_x", o_x, c10, 8192);
    near("after_abort_y", o_y, s10, 8192);

    // 16-bit engine, rotation by -30 degrees, start held for two back-to-back runs
    s_mode = 1'b1; s_vector = 1'b0; s_x = 16'sd19898; s_y = 16'sd0; s_z = -16'sd5461; s_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d1 = -1; d2 = -1; r1x = 0; r1y = 0; r2x = 0; r2y = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 16) s_start = 1'b0;
      if (s_done) begin
        if (d1 < 0) begin
          d1 = k; r1x = int'(s_ox); r1y = int'(s_oy);
        end else if (d2 < 0) begin
          d2 = k; r2x = int'(s_ox); r2y = int'(s_oy);
        end
      end
    end
    chk("w16_latency", d1, 15);
    chk("w16_done_spacing", d2 - d1, 16);
    near("w16_x1", r1x, 28378, 64);
    near("w16_y1", r1y, -16384, 64);
    near("w16_x2", r2x, 28378, 64);
    near("w16_y2", r2y, -16384, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
